// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared state type and load clamp for the up/down counter family
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cnt_state_t;

    // Clamp a requested load value into the legal count range 0..mod-1.
    function automatic int unsigned sat_load(input int unsigned val, input int unsigned mod);
        return (val >= mod) ? (mod - 1) : val;
    endfunction

endpackage

// File: rtl/sync_up_counter.sv
// rtl/sync_up_counter.sv - synchronous modulo-MOD up counter with free-run and one-shot modes
//
// Ports:
//   clk       clock, all state changes on rising edge
//   rst       asynchronous active-high reset
//   en        count enable (used only in RUN)
//   clr       synchronous clear: q=0, IDLE, ovf=0
//   load      synchronous load of saturated load_val, state unchanged
//   load_val  load value, clamped to MOD-1
//   start     IDLE -> RUN (resume), DONE -> RUN with q=0
//   stop      RUN -> IDLE, q holds
//   oneshot   1 = stop at terminal count, 0 = wrap
//   q         registered count
//   tc        combinational terminal count (q == MOD-1)
//   wrap      registered one-cycle pulse after a MOD-1 -> 0 wrap
//   ovf       sticky wrap flag
//   busy      state == RUN
//   done      state == DONE
module sync_up_counter
    import counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MOD   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    input  logic             oneshot,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    generate
        if (MOD < 2 || MOD > (2 ** WIDTH)) begin : g_bad_mod
            $fatal(1, "sync_up_counter: MOD out of range 2..2**WIDTH");
        end
    endgenerate

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MOD - 1);

    cnt_state_t       r_state;
    cnt_state_t       w_state_nxt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_nxt;
    logic             r_wrap;
    logic             w_wrap_nxt;
    logic             r_ovf;
    logic             w_ovf_nxt;

    // Priority: clr > load > start/stop > count.
    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_wrap_nxt  = 1'b0;
        w_ovf_nxt   = r_ovf;
        if (clr) begin
            w_q_nxt     = '0;
            w_state_nxt = IDLE;
            w_ovf_nxt   = 1'b0;
        end else if (load) begin
            w_q_nxt = WIDTH'(sat_load(32'(load_val), MOD));
        end else begin
            case (r_state)
                IDLE: begin
                    // Resume from the held value; q is deliberately not reset.
                    if (start) begin
                        w_state_nxt = RUN;
                    end
                end
                DONE: begin
                    if (start) begin
                        w_q_nxt     = '0;
                        w_state_nxt = RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        w_state_nxt = IDLE;
                    end else if (en) begin
                        if (r_q == LAST) begin
                            if (oneshot) begin
                                w_state_nxt = DONE;
                            end else begin
                                w_q_nxt    = '0;
                                w_wrap_nxt = 1'b1;
                                w_ovf_nxt  = 1'b1;
                            end
                        end else begin
                            w_q_nxt = r_q + 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_q     <= '0;
            r_wrap  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_wrap  <= w_wrap_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    assign q    = r_q;
    assign tc   = (r_q == LAST);
    assign wrap = r_wrap;
    assign ovf  = r_ovf;
    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);

endmodule
